// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared constants and FSM state type for the memory responder.
//            Holds the default address/data widths, the default access
//            latency, the latency counter width and the responder state enum.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int c_addr_w  = 9;   // 512 words
    localparam int c_data_w  = 32;
    localparam int c_latency = 2;   // accept-to-Done cycles, legal 1..7
    localparam int c_cnt_w   = 3;   // wide enough for LATENCY-1 up to 6

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_array
// Purpose  : Single-port 2^ADDR_W x DATA_W storage with synchronous write and
//            registered read. Not reset, so contents survive the responder
//            reset. The read register only updates when a read is requested,
//            so it holds the last read word between reads.
// Ports    : clk     - clock
//            i_we    - write enable
//            i_re    - read enable (loads o_rdata)
//            i_addr  - word address
//            i_wdata - write data
//            o_rdata - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder for a CPU control unit. Accepts a single
//            read or write strobe in IDLE, waits LATENCY cycles, performs the
//            access and raises Done until both strobes are released
//            (four-phase handshake). Simultaneous Read and Write is rejected
//            with a one-cycle Err pulse.
// Ports    : clock   - clock, rising edge
//            clear   - asynchronous active-low reset
//            Read    - read strobe
//            Write   - write strobe
//            Address - word address (from MAR)
//            DataIn  - write data (from MDR)
//            Mdatain - read data returned to MDR
//            Done    - access complete, held until strobes drop
//            Err     - one-cycle pulse on a rejected request
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = c_addr_w,
    parameter int DATA_W  = c_data_w,
    parameter int LATENCY = c_latency
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] Mdatain,
    output logic              Done,
    output logic              Err
);

    localparam int                 c_cnt_init_i = LATENCY - 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init   = c_cnt_init_i[c_cnt_w-1:0];

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_op_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_done;
    logic                r_err;
    logic                r_both_q;    // both strobes were high last IDLE cycle
    logic                r_rd_valid;  // a read has completed since reset

    logic                w_both;
    logic                w_fire;
    logic                w_mem_we;
    logic                w_mem_re;
    logic [DATA_W-1:0]   w_rdata;

    assign w_both   = Read & Write;
    // The access happens on the BUSY->ACK edge, i.e. the last BUSY cycle.
    assign w_fire   = (r_state == BUSY) && (r_cnt == '0);
    assign w_mem_we = w_fire &  r_op_wr;
    assign w_mem_re = w_fire & ~r_op_wr;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op_wr    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_both_q   <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_both_q <= w_both;
                    if (w_both) begin
                        // Pulse once per rejected request, even if held.
                        r_err <= ~r_both_q;
                    end else if (Read || Write) begin
                        r_addr  <= Address;
                        r_op_wr <= Write;
                        if (Write) begin
                            r_data <= DataIn;
                        end
                        r_cnt   <= c_cnt_init;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= ACK;
                        r_done  <= 1'b1;
                        if (!r_op_wr) begin
                            r_rd_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ACK: begin
                    if (!Read && !Write) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk     (clock),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (r_addr),
        .i_wdata (r_data),
        .o_rdata (w_rdata)
    );

    // The read register has no reset; mask it until the first read lands so
    // Mdatain reads zero out of reset.
    assign Mdatain = r_rd_valid ? w_rdata : '0;
    assign Done    = r_done;
    assign Err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Scoreboard bench for mem_responder. Three instances with
//            LATENCY 2, 7 and 1. Stimulus pushes the expected Done cycle and
//            Mdatain value; a monitor pops and compares on each Done rise.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  rd, wr, done, err;
    logic [8:0]  addr [3];
    logic [31:0] din  [3];
    logic [31:0] mdo  [3];

    mem_responder #(.ADDR_W(9), .DATA_W(32), .LATENCY(2)) u_dut0 (
        .clock(clk), .clear(rst_n), .Read(rd[0]), .Write(wr[0]), .Address(addr[0]),
        .DataIn(din[0]), .Mdatain(mdo[0]), .Done(done[0]), .Err(err[0]));
    mem_responder #(.ADDR_W(9), .DATA_W(32), .LATENCY(7)) u_dut1 (
        .clock(clk), .clear(rst_n), .Read(rd[1]), .Write(wr[1]), .Address(addr[1]),
        .DataIn(din[1]), .Mdatain(mdo[1]), .Done(done[1]), .Err(err[1]));
    mem_responder #(.ADDR_W(9), .DATA_W(32), .LATENCY(1)) u_dut2 (
        .clock(clk), .clear(rst_n), .Read(rd[2]), .Write(wr[2]), .Address(addr[2]),
        .DataIn(din[2]), .Mdatain(mdo[2]), .Done(done[2]), .Err(err[2]));

    typedef struct {
        int          due;
        logic [31:0] mdata;
    } exp_t;

    exp_t        exq [3][$];
    exp_t        mon_e;
    logic [31:0] mdl [3][512];
    logic [31:0] last_rd [3];
    logic [2:0]  prev_done = 3'b000;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(int i);
        case (i)
            0:       return 2;
            1:       return 7;
            default: return 1;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compare each Done rise against the oldest expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i] && !prev_done[i]) begin
                if (exq[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done dut%0d at cycle %0d", i, cyc);
                end else begin
                    mon_e = exq[i].pop_front();
                    chk($sformatf("done_cycle_dut%0d", i), 32'(cyc), 32'(mon_e.due));
                    chk($sformatf("mdatain_dut%0d", i), mdo[i], mon_e.mdata);
                end
            end
        end
        prev_done = done;
    end

    // Called at the negedge where the strobe is presented; accept is the next edge.
    task automatic push_exp(int i, bit is_rd, logic [8:0] a);
        exp_t e;
        e.due = cyc + 1 + lat(i);
        if (is_rd) last_rd[i] = mdl[i][a];
        e.mdata = last_rd[i];
        exq[i].push_back(e);
    endtask

    task automatic finish_acc(int i, bit wiggle, int hold);
        int n = 0;
        while (!done[i] && n < 40) begin
            @(negedge clk);
            n++;
            if (wiggle) begin
                addr[i] = 9'($urandom);
                din[i]  = $urandom;
            end
        end
        if (!done[i]) begin
            checks++;
            errors++;
            $display("FAIL done_timeout dut%0d at cycle %0d", i, cyc);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("done_held", 32'(done[i]), 32'd1);
            chk("mdatain_held", mdo[i], last_rd[i]);
        end
        rd[i] = 1'b0;
        wr[i] = 1'b0;
        @(negedge clk);
        chk($sformatf("done_released_dut%0d", i), 32'(done[i]), 32'd0);
    endtask

    task automatic access(int i, bit is_rd, logic [8:0] a, logic [31:0] d, bit wiggle, int hold);
        rd[i]   = is_rd;
        wr[i]   = !is_rd;
        addr[i] = a;
        din[i]  = d;
        if (!is_rd) mdl[i][a] = d;
        push_exp(i, is_rd, a);
        finish_acc(i, wiggle, hold);
    endtask

    initial begin
        rst_n = 1'b0;
        rd    = '0;
        wr    = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i]    = '0;
            din[i]     = '0;
            last_rd[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_done", 32'(done[i]), 32'd0);
            chk("reset_err", 32'(err[i]), 32'd0);
            chk("reset_mdatain", mdo[i], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back, LATENCY 2
        access(0, 0, 9'h054, 32'h0000_00A5, 0, 0);
        access(0, 1, 9'h054, 32'h0, 0, 0);

        // Read held 4 cycles past Done: Done stays, no second access
        access(0, 1, 9'h054, 32'h0, 0, 4);

        // Both strobes held 3 cycles: Err pulses once, no access
        rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 9'h054; din[0] = 32'hDEAD_0000;
        @(negedge clk);
        chk("err_pulse", 32'(err[0]), 32'd1);
        chk("err_no_done", 32'(done[0]), 32'd0);
        @(negedge clk);
        chk("err_one_cycle", 32'(err[0]), 32'd0);
        @(negedge clk);
        chk("err_still_low", 32'(err[0]), 32'd0);
        chk("err_no_done2", 32'(done[0]), 32'd0);
        rd[0] = 1'b0; wr[0] = 1'b0;
        @(negedge clk);
        access(0, 1, 9'h054, 32'h0, 0, 0);

        // Write aborted by reset during BUSY leaves old contents
        access(0, 0, 9'h1FF, 32'hCAFE_F00D, 0, 0);
        wr[0] = 1'b1; addr[0] = 9'h1FF; din[0] = 32'hFFFF_FFFF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("abort_reset_done", 32'(done[i]), 32'd0);
            chk("abort_reset_mdatain", mdo[i], 32'd0);
            last_rd[i] = '0;
        end
        // Read held high through reset is accepted on the first edge after
        wr[0] = 1'b0; rd[0] = 1'b1; addr[0] = 9'h1FF;
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(0, 1, 9'h1FF);
        finish_acc(0, 0, 0);

        // LATENCY 7 read with Address/DataIn wiggling during BUSY
        access(1, 0, 9'h000, 32'h0BAD_F00D, 0, 0);
        access(1, 0, 9'h155, 32'h55AA_55AA, 0, 0);
        access(1, 1, 9'h000, 32'h0, 1, 0);
        access(1, 1, 9'h155, 32'h0, 0, 0);

        // Back-to-back write then read; write leaves Mdatain alone
        access(0, 1, 9'h054, 32'h0, 0, 0);
        access(0, 0, 9'h010, 32'h1234_5678, 0, 0);
        access(0, 1, 9'h010, 32'h0, 0, 0);

        // LATENCY 1
        access(2, 0, 9'h0AB, 32'h1111_2222, 0, 0);
        access(2, 1, 9'h0AB, 32'h0, 0, 0);
        access(2, 0, 9'h0AB, 32'h3333_4444, 0, 0);
        access(2, 1, 9'h0AB, 32'h0, 0, 0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("scoreboard_empty_dut%0d", i), 32'(exq[i].size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
